// File: rtl/uart_txrx_core.sv
// Purpose     : 8N1 UART transmitter and receiver with ASCII command pre-decode on received bytes.
// Latency     : TX drives the start bit on the accept edge; RX DONE_o rises N/2+1 clocks into the stop bit.
// Backpressure: STB_o=0 while a frame is on the wire; REQ_i is ignored until STB_o returns to 1.
//
// Ports: CK_i clock, XARST_i sync active-low reset,
//        TX: BYTEs_i/REQ_i in, TXD_o serial out, STB_o ready,
//        RX: RXD_i serial in (pre-synchronized), BYTEs_o last good byte, HEXs_o/CRLF_DET_o/W_DET_o/R_DET_o
//            decode of BYTEs_o, DONE_o one-cycle received pulse.
module uart_txrx_core #(
    parameter int C_F_CK = 135_000_000,
    parameter int C_BAUD = 31_250
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic [7:0] BYTEs_i,
    input  logic       REQ_i,
    output logic       TXD_o,
    output logic       STB_o,
    input  logic       RXD_i,
    output logic [7:0] BYTEs_o,
    output logic [3:0] HEXs_o,
    output logic       CRLF_DET_o,
    output logic       W_DET_o,
    output logic       R_DET_o,
    output logic       DONE_o
);

    // Clocks per bit, rounded to nearest.
    localparam int N  = (C_F_CK + C_BAUD / 2) / C_BAUD;
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(N / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_sh;

    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            TXD_o    <= 1'b1;
            STB_o    <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (REQ_i) begin
                        tx_sh    <= BYTEs_i;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        TXD_o    <= 1'b0;
                        STB_o    <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        // Shift register always presents the next data bit at [0].
                        tx_cnt   <= '0;
                        TXD_o    <= tx_sh[0];
                        tx_sh    <= {1'b0, tx_sh[7:1]};
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            TXD_o    <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            TXD_o  <= tx_sh[0];
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        STB_o    <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_sh;

    logic [3:0]      hex_nxt;
    logic            crlf_nxt;
    logic            w_nxt;
    logic            r_nxt;

    // Decode of the byte assembled in rx_sh; only registered on a good stop bit.
    always_comb begin
        hex_nxt = 4'd0;
        if (rx_sh >= 8'h30 && rx_sh <= 8'h39) begin
            hex_nxt = rx_sh[3:0];
        end else if ((rx_sh >= 8'h41 && rx_sh <= 8'h46) || (rx_sh >= 8'h61 && rx_sh <= 8'h66)) begin
            hex_nxt = rx_sh[3:0] + 4'd9;
        end
        crlf_nxt = (rx_sh == 8'h0D) || (rx_sh == 8'h0A);
        w_nxt    = (rx_sh == 8'h57) || (rx_sh == 8'h77);
        r_nxt    = (rx_sh == 8'h52) || (rx_sh == 8'h72);
    end

    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            BYTEs_o    <= '0;
            HEXs_o     <= '0;
            CRLF_DET_o <= 1'b0;
            W_DET_o    <= 1'b0;
            R_DET_o    <= 1'b0;
            DONE_o     <= 1'b0;
        end else begin
            DONE_o <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!RXD_i) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= RXD_i ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {RXD_i, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (RXD_i) begin
                            BYTEs_o    <= rx_sh;
                            HEXs_o     <= hex_nxt;
                            CRLF_DET_o <= crlf_nxt;
                            W_DET_o    <= w_nxt;
                            R_DET_o    <= r_nxt;
                            DONE_o     <= 1'b1;
                            rx_state   <= RX_IDLE;
                        end else begin
                            rx_state <= RX_BREAK;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_BREAK: begin
                    // Framing error: wait for the line to go idle before hunting again.
                    if (RXD_i) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txrx_core.sv
module tb_uart_txrx_core;

    localparam int F_CK = 1000;
    localparam int BAUD = 100;
    localparam int N    = (F_CK + BAUD / 2) / BAUD;

    logic       ck = 1'b0;
    logic       arst_n;
    logic [7:0] tx_byte;
    logic       req;
    logic       txd;
    logic       stb;
    logic       rxd_drv;
    logic       loop_en;
    logic       rxd;
    logic [7:0] rx_byte;
    logic [3:0] hex;
    logic       crlf;
    logic       wdet;
    logic       rdet;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [7:0] sb_q[$];
    logic [7:0] mon_exp;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_txrx_core #(.C_F_CK(F_CK), .C_BAUD(BAUD)) dut (
        .CK_i(ck), .XARST_i(arst_n), .BYTEs_i(tx_byte), .REQ_i(req),
        .TXD_o(txd), .STB_o(stb), .RXD_i(rxd), .BYTEs_o(rx_byte),
        .HEXs_o(hex), .CRLF_DET_o(crlf), .W_DET_o(wdet), .R_DET_o(rdet),
        .DONE_o(done)
    );

    always #5 ck = ~ck;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (ASCII rules) ----------------
    function automatic logic [3:0] m_hex(input logic [7:0] b);
        int v;
        v = int'(b);
        if (v >= 48 && v <= 57)  return 4'(v - 48);
        if (v >= 65 && v <= 70)  return 4'(v - 55);
        if (v >= 97 && v <= 102) return 4'(v - 87);
        return 4'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_decode(input string tag, input logic [7:0] b);
        check({tag, "_byte"}, rx_byte, b);
        check({tag, "_hex"},  hex,  m_hex(b));
        check({tag, "_crlf"}, crlf, (b == 8'd13 || b == 8'd10));
        check({tag, "_w"},    wdet, (b == "W" || b == "w"));
        check({tag, "_r"},    rdet, (b == "R" || b == "r"));
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic wait_stb(input logic v, input string name);
        int k;
        k = 0;
        while (stb !== v && k < 300) begin
            tick();
            k++;
        end
        check(name, stb, v);
    endtask

    // Drive one serial frame on RXD; report the stop-bit clock on which DONE was seen (0 = never).
    task automatic send_rx(input logic [7:0] b, input logic stop_v, output int done_k);
        rxd_drv = 1'b0;
        repeat (N) tick();
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (N) tick();
        end
        rxd_drv = stop_v;
        done_k = 0;
        for (int k = 1; k <= N; k++) begin
            tick();
            if (done === 1'b1 && done_k == 0) done_k = k;
        end
    endtask

    // Transmit one byte and compare every bit slot against the 8N1 frame.
    task automatic tx_frame(input logic [7:0] b);
        logic [9:0] fr;
        int good[10];
        int low_cnt;
        int s;
        fr = {1'b1, b, 1'b0};
        for (int j = 0; j < 10; j++) good[j] = 0;
        wait_stb(1'b1, "tx_idle");
        tx_byte = b;
        req = 1'b1;
        tick();
        check($sformatf("tx%02h_accept_stb", b), stb, 1'b0);
        req = 1'b0;
        low_cnt = 0;
        s = 0;
        while (stb === 1'b0 && s < 200) begin
            if (s < 10 * N && txd === fr[s / N]) good[s / N]++;
            if (s == 15) tx_byte = ~b;
            low_cnt++;
            s++;
            tick();
        end
        for (int j = 0; j < 10; j++)
            check($sformatf("tx%02h_slot%0d", b, j), good[j], N);
        check($sformatf("tx%02h_stb_low", b), low_cnt, 10 * N);
        check($sformatf("tx%02h_idle_txd", b), txd, 1'b1);
    endtask

    // DONE monitor and loopback scoreboard.
    always @(negedge ck) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (loop_en) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL loop_unexpected_done: got byte 0x%02h, expected no pulse", rx_byte);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check_decode($sformatf("loop%02h", mon_exp), mon_exp);
                end
            end
        end
    end

    typedef struct {
        logic [7:0] din;
        logic [3:0] hex;
        logic       crlf;
        logic       w;
        logic       r;
    } rx_vec_t;

    rx_vec_t vecs[10];

    initial begin
        int d0;
        int dk;
        logic [7:0] b;

        vecs[0] = '{8'h57, 4'h0, 1'b0, 1'b1, 1'b0};  // 'W'
        vecs[1] = '{8'h72, 4'h0, 1'b0, 1'b0, 1'b1};  // 'r'
        vecs[2] = '{8'h0D, 4'h0, 1'b1, 1'b0, 1'b0};  // CR
        vecs[3] = '{8'h61, 4'hA, 1'b0, 1'b0, 1'b0};  // 'a'
        vecs[4] = '{8'h37, 4'h7, 1'b0, 1'b0, 1'b0};  // '7'
        vecs[5] = '{8'h46, 4'hF, 1'b0, 1'b0, 1'b0};  // 'F'
        vecs[6] = '{8'h0A, 4'h0, 1'b1, 1'b0, 1'b0};  // LF
        vecs[7] = '{8'h77, 4'h0, 1'b0, 1'b1, 1'b0};  // 'w'
        vecs[8] = '{8'h52, 4'h0, 1'b0, 1'b0, 1'b1};  // 'R'
        vecs[9] = '{8'h67, 4'h0, 1'b0, 1'b0, 1'b0};  // 'g'

        arst_n  = 1'b0;
        req     = 1'b0;
        tx_byte = 8'h00;
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        tick();
        tick();
        check("rst_txd", txd, 1'b1);
        check("rst_stb", stb, 1'b1);
        check("rst_byte", rx_byte, 8'h00);
        check("rst_hex", hex, 4'h0);
        check("rst_crlf", crlf, 1'b0);
        check("rst_w", wdet, 1'b0);
        check("rst_r", rdet, 1'b0);
        check("rst_done", done, 1'b0);
        arst_n = 1'b1;
        tick();

        // Alternating pattern: every slot must hold for exactly N clocks.
        tx_frame(8'h55);

        // Table-driven receive decode.
        for (int i = 0; i < 10; i++) begin
            d0 = done_cnt;
            send_rx(vecs[i].din, 1'b1, dk);
            check($sformatf("vec%0d_pulses", i), done_cnt - d0, 1);
            check($sformatf("vec%0d_latency", i), (dk >= 1 && dk <= N / 2 + 2), 1'b1);
            check($sformatf("vec%0d_byte", i), rx_byte, vecs[i].din);
            check($sformatf("vec%0d_hex", i), hex, vecs[i].hex);
            check($sformatf("vec%0d_crlf", i), crlf, vecs[i].crlf);
            check($sformatf("vec%0d_w", i), wdet, vecs[i].w);
            check($sformatf("vec%0d_r", i), rdet, vecs[i].r);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Short low glitch must be rejected as a false start.
        d0 = done_cnt;
        rxd_drv = 1'b0;
        repeat (3) tick();
        rxd_drv = 1'b1;
        repeat (2 * N) tick();
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_byte_hold", rx_byte, 8'h67);
        send_rx(8'h31, 1'b1, dk);
        check("glitch_next_pulses", done_cnt - d0, 1);
        check_decode("glitch_next", 8'h31);

        // Framing error: stop bit low.
        d0 = done_cnt;
        send_rx(8'hAA, 1'b0, dk);
        rxd_drv = 1'b1;
        repeat (N) tick();
        check("frame_err_no_done", done_cnt - d0, 0);
        check("frame_err_byte_hold", rx_byte, 8'h31);
        check("frame_err_hex_hold", hex, 4'h1);
        send_rx(8'h42, 1'b1, dk);
        check("frame_err_next_pulses", done_cnt - d0, 1);
        check_decode("frame_err_next", 8'h42);

        // Randomized receive against the ASCII model.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) b = 8'($urandom_range(0, 255));
            else b = 8'($urandom_range(8'h28, 8'h7A));
            repeat ($urandom_range(0, 2 * N)) tick();
            d0 = done_cnt;
            send_rx(b, 1'b1, dk);
            check($sformatf("rnd%0d_pulses", i), done_cnt - d0, 1);
            check_decode($sformatf("rnd%0d", i), b);
        end

        // Randomized transmit.
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            tx_frame(8'($urandom_range(0, 255)));
        end

        // Reset 40 clocks into a frame.
        wait_stb(1'b1, "rst_mid_idle");
        tx_byte = 8'hC3;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (40) tick();
        check("rst_mid_pre_txd", txd, 1'b0);
        arst_n = 1'b0;
        tick();
        check("rst_mid_txd", txd, 1'b1);
        check("rst_mid_stb", stb, 1'b1);
        check("rst_mid_byte", rx_byte, 8'h00);
        check("rst_mid_hex", hex, 4'h0);
        arst_n = 1'b1;
        tick();
        tx_frame(8'hC3);

        // Loopback sweep of every byte value.
        loop_en = 1'b1;
        repeat (N) tick();
        d0 = done_cnt;
        for (int v = 0; v < 256; v++) begin
            wait_stb(1'b1, "loop_idle");
            tick();
            tx_byte = 8'(v);
            req = 1'b1;
            wait_stb(1'b0, "loop_accept");
            sb_q.push_back(8'(v));
            req = 1'b0;
        end
        wait_stb(1'b1, "loop_final_idle");
        repeat (N) tick();
        check("loop_pulses", done_cnt - d0, 256);
        check("loop_queue_empty", sb_q.size(), 0);
        loop_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_txrx_core.md
Name: uart_txrx_core

Overview:
- Fixed-format 8N1 UART transmitter and receiver in one block. No parity, 1 start bit, 8 data bits LSB first, 1 stop bit.
- The receiver adds ASCII command pre-decode (hex nibble, CR/LF, 'W', 'R') for the register-access parser that sits above it.
- The TX and RX halves are independent. They share only the clock, the reset and the baud parameters.

Parameters:
- C_F_CK, default 135_000_000: clock frequency in Hz.
- C_BAUD, default 31_250: bit rate in bps.
- Derived constant: N = (C_F_CK + C_BAUD/2) / C_BAUD, the clocks per bit (integer). N must be ≥ 4. With 1000/100, N = 10.

Ports:
- CK_i  in  1  clock; all logic is on the rising edge.
- XARST_i  in  1  reset; synchronous, active-low.
- BYTEs_i  in  8  byte to transmit; sampled at TX accept.
- REQ_i  in  1  transmit request; level-sensitive.
- TXD_o  out  1  serial output; idle high.
- STB_o  out  1  TX ready; 1 = idle and able to accept.
- RXD_i  in  1  serial input; already synchronized by the parent, used directly.
- BYTEs_o  out  8  last correctly received byte.
- HEXs_o  out  4  hex value of BYTEs_o.
- CRLF_DET_o  out  1  BYTEs_o is 0x0D or 0x0A.
- W_DET_o  out  1  BYTEs_o is 'W' (0x57) or 'w' (0x77).
- R_DET_o  out  1  BYTEs_o is 'R' (0x52) or 'r' (0x72).
- DONE_o  out  1  one-cycle pulse when a byte has been received.

Behaviour:
- Reset (XARST_i=0 at a clock edge):
  - TXD_o=1, STB_o=1.
  - BYTEs_o=0x00, HEXs_o=0, CRLF_DET_o/W_DET_o/R_DET_o=0, DONE_o=0.
  - Both state machines return to IDLE and all counters clear.
  - Reset mid-frame aborts the frame immediately; TXD_o returns high on the next edge.
- TX state machine: IDLE → START → DATA → STOP → IDLE.
  - Accept condition: a clock edge where state is IDLE and REQ_i=1. At that edge BYTEs_i is latched, STB_o drops to 0 and TXD_o goes 0 (START).
  - START lasts N clocks.
  - DATA sends bits 0..7, N clocks each.
  - STOP drives TXD_o=1 for N clocks.
  - After STOP, the machine returns to IDLE and STB_o goes back to 1.
  - STB_o is low for exactly 10·N clocks per frame.
  - If REQ_i is still 1 when STB_o returns to 1, a new frame starts on the next edge. The requester must drop REQ_i after seeing STB_o fall.
  - BYTEs_i changes during a frame have no effect.
- RX state machine: IDLE → START → DATA → STOP.
  - IDLE: wait for RXD_i=0.
  - START: sample RXD_i after N/2 clocks (mid start bit). If it is 1, treat as a false start and return to IDLE with no output change.
  - DATA: sample every N clocks at mid-bit, 8 bits, LSB first.
  - STOP: sample at mid stop bit.
    - Stop bit = 1: on the next edge, update BYTEs_o and all decode outputs, and pulse DONE_o=1 for exactly one clock. Then return to IDLE, which can detect a new start bit immediately.
    - Stop bit = 0 (framing error): no DONE_o and no output update. Stay in a BREAK wait until RXD_i=1, then go to IDLE.
- Decode outputs:
  - They are registered and change only together with BYTEs_o. They hold their value until the next good byte.
  - HEXs_o: '0'–'9' map to 0–9; 'A'–'F' and 'a'–'f' map to 10–15; any other byte gives 0.
- Total RX latency: DONE_o rises within N/2+2 clocks after the stop-bit start edge.
- TX and RX may run simultaneously, including TX looped back to RX.

Test Plan:
- Loopback with C_F_CK=1000, C_BAUD=100, TXD_o wired to RXD_i. The requester raises REQ_i one clock after STB_o rises, drops it after STB_o falls, then increments the byte. Bytes 0x00..0xFF are sent. Required: DONE_o pulses once per frame, BYTEs_o matches each sent byte, and there are 256 pulses.
- Send 0x55 with N=10. Required TXD_o sequence: 0, then 1,0,1,0,1,0,1,0, then 1, each for 10 clocks. STB_o is low for 100 clocks.
- Receive 'W', 'r', 0x0D and 'a' in turn:
  - 'W' → W_DET_o=1, R_DET_o=0.
  - 'r' → R_DET_o=1.
  - 0x0D → CRLF_DET_o=1.
  - 'a' → HEXs_o=0xA, and W_DET_o, R_DET_o and CRLF_DET_o all 0.
- Drive RXD_i low for 3 clocks, then high. Required: no DONE_o, and the next valid frame 0x31 is received with HEXs_o=1.
- Send a frame with stop bit 0 and data 0xAA. Required: no DONE_o, BYTEs_o unchanged. After the line returns high, the next valid frame 0x42 is received.
- Assert reset 40 clocks into a TX frame. Required: TXD_o=1 and STB_o=1 on the next edge. The next REQ_i then transmits a full, correct frame.
